// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 word-copy DMA master.
// Holds the controller state encoding and the AXI word size.
package axi4_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/axi4_wr_chan.sv
// Write address/data channel tracker for the DMA master.
// AW and W complete independently; both_done marks the last of the two.
module axi4_wr_chan (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    assign awvalid   = active && !aw_done;
    assign wvalid    = active && !w_done;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign both_done = (aw_done || aw_hs) && (w_done || w_hs);

    // Flags clear on the way out so the next write starts fresh.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!active || both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/axi4_dma_master.sv
// Single-outstanding AXI4 word-copy DMA master.
// Reads one word, writes it, waits for the response, repeats.
module axi4_dma_master
    import axi4_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len_words,
    input  logic        dst_fixed,
    output logic        busy,
    output logic        done,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready
);

    state_t      state;
    state_t      state_n;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] remaining;
    logic [31:0] wbuf;
    logic        fixed;
    logic        wr_active;
    logic        wr_both;

    axi4_wr_chan u_wr_chan (
        .clk       (clk),
        .resetn    (resetn),
        .active    (wr_active),
        .awready   (mem_axi_awready),
        .wready    (mem_axi_wready),
        .awvalid   (mem_axi_awvalid),
        .wvalid    (mem_axi_wvalid),
        .both_done (wr_both)
    );

    assign mem_axi_araddr = src;
    assign mem_axi_awaddr = dst;
    assign mem_axi_wdata  = wbuf;
    assign mem_axi_wstrb  = 4'b1111;
    assign mem_axi_arprot = PROT;
    assign mem_axi_awprot = PROT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n         = state;
        mem_axi_arvalid = 1'b0;
        mem_axi_rready  = 1'b0;
        mem_axi_bready  = 1'b0;
        wr_active       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (len_words == 16'd0) ? FINISH : RD_ADDR;
            end
            RD_ADDR: begin
                busy            = 1'b1;
                mem_axi_arvalid = 1'b1;
                if (mem_axi_arready) state_n = RD_DATA;
            end
            RD_DATA: begin
                busy           = 1'b1;
                mem_axi_rready = 1'b1;
                if (mem_axi_rvalid) state_n = WR_REQ;
            end
            WR_REQ: begin
                busy      = 1'b1;
                wr_active = 1'b1;
                if (wr_both) state_n = WR_RESP;
            end
            WR_RESP: begin
                busy           = 1'b1;
                mem_axi_bready = 1'b1;
                if (mem_axi_bvalid)
                    state_n = (remaining == 16'd1) ? FINISH : RD_ADDR;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src       <= 32'd0;
            dst       <= 32'd0;
            remaining <= 16'd0;
            wbuf      <= 32'd0;
            fixed     <= 1'b0;
        end else if (state == IDLE && start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= len_words;
            fixed     <= dst_fixed;
        end else if (state == RD_DATA && mem_axi_rvalid) begin
            wbuf <= mem_axi_rdata;
            src  <= src + WORD_BYTES;
        end else if (state == WR_RESP && mem_axi_bvalid) begin
            remaining <= remaining - 16'd1;
            if (!fixed) dst <= dst + WORD_BYTES;
        end
    end

endmodule

// File: tb/tb_axi4_dma_master.sv
// Bench for axi4_dma_master: latency-configurable AXI responder,
// per-handshake scoreboard built from the job parameters.
module tb_axi4_dma_master;

    localparam logic [2:0] PROT = 3'b101;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        dst_fixed;
    logic        busy;
    logic        done;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arprot, awprot;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    axi4_dma_master #(.PROT(PROT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len_words       (len_words),
        .dst_fixed       (dst_fixed),
        .busy            (busy),
        .done            (done),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    logic [31:0] exp_ra[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    bit rand_lat = 0;
    bit spurious = 0;
    int lat_ar = 0, lat_r = 0, lat_aw = 0, lat_w = 0, lat_b = 0;
    int cur_ar, cur_r, cur_aw, cur_w, cur_b;
    int cnt_ar, cnt_aw, cnt_w, rd_wait, b_wait;
    bit rd_out, aw_got, w_got, b_last;
    logic [31:0] rd_addr;
    int done_cnt = 0, av_cnt = 0, aw_wait = 0, w_cycles = 0;

    logic        p_arvalid, p_arready, p_rvalid, p_rready;
    logic        p_awvalid, p_awready, p_wvalid, p_wready;
    logic        p_bvalid, p_bready;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    function automatic int pick();
        return int'($urandom_range(0, 3));
    endfunction

    function automatic int eff(input int cur, input int lat);
        return rand_lat ? cur : lat;
    endfunction

    task automatic snap();
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_rvalid  = rvalid;  p_rready  = rready;
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid  = wvalid;  p_wready  = wready;
        p_wdata   = wdata;   p_wstrb   = wstrb;
        p_bvalid  = bvalid;  p_bready  = bready;
    endtask

    // Responder and monitor: handshakes of the previous edge are
    // judged at each falling edge, then new inputs are driven.
    initial begin
        logic [31:0] e;
        arready = 0; rvalid = 0; rdata = 0; awready = 0;
        wready = 0; bvalid = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rd_out = 0; aw_got = 0; w_got = 0; b_last = 0;
                cnt_ar = 0; cnt_aw = 0; cnt_w = 0;
                rd_wait = 0; b_wait = 0;
                cur_ar = 0; cur_r = 0; cur_aw = 0; cur_w = 0; cur_b = 0;
                arready = 0; rvalid = 0; rdata = 0;
                awready = 0; wready = 0; bvalid = 0;
                snap();
                continue;
            end
            b_last = 0;
            if (p_arvalid && p_arready) begin
                check("ar_overlap", 64'(aw_got || w_got), 64'd0);
                check("arprot", 64'(arprot), 64'(PROT));
                if (exp_ra.size() == 0) begin
                    check("ar_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_ra.pop_front();
                    check("araddr", 64'(p_araddr), 64'(e));
                end
                rd_out = 1; rd_addr = p_araddr; rd_wait = 0;
                cur_r = pick(); cur_ar = pick(); cnt_ar = 0;
            end else if (p_arvalid) cnt_ar++;
            if (p_rvalid && p_rready) rd_out = 0;
            if (p_awvalid && p_awready) begin
                check("aw_overlap", 64'(rd_out), 64'd0);
                check("awprot", 64'(awprot), 64'(PROT));
                if (exp_wa.size() == 0) begin
                    check("aw_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_wa.pop_front();
                    check("awaddr", 64'(p_awaddr), 64'(e));
                end
                aw_got = 1; cnt_aw = 0; cur_aw = pick();
            end else if (p_awvalid) begin
                cnt_aw++;
                aw_wait++;
            end
            if (p_wvalid) w_cycles++;
            if (p_wvalid && p_wready) begin
                check("w_overlap", 64'(rd_out), 64'd0);
                check("wstrb", 64'(p_wstrb), 64'hF);
                if (exp_wd.size() == 0) begin
                    check("w_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_wd.pop_front();
                    check("wdata", 64'(p_wdata), 64'(e));
                end
                w_got = 1; cnt_w = 0; cur_w = pick();
            end else if (p_wvalid) cnt_w++;
            if (p_bvalid && p_bready) begin
                aw_got = 0; w_got = 0; b_wait = 0; cur_b = pick();
                b_last = (exp_wa.size() == 0 && exp_ra.size() == 0);
            end
            if (p_arvalid && !p_arready) begin
                check("ar_hold", 64'(arvalid), 64'd1);
                check("araddr_hold", 64'(araddr), 64'(p_araddr));
            end
            if (p_awvalid && !p_awready) begin
                check("aw_hold", 64'(awvalid), 64'd1);
                check("awaddr_hold", 64'(awaddr), 64'(p_awaddr));
            end
            if (p_wvalid && !p_wready) begin
                check("w_hold", 64'(wvalid), 64'd1);
                check("wdata_hold", 64'(wdata), 64'(p_wdata));
            end
            if (bready) check("bready_after_both", 64'(aw_got && w_got), 64'd1);
            if (b_last) check("done_after_last_b", 64'(done), 64'd1);
            if (done) begin
                done_cnt++;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            if (arvalid || awvalid || wvalid) av_cnt++;

            arready = (cnt_ar >= eff(cur_ar, lat_ar));
            awready = (cnt_aw >= eff(cur_aw, lat_aw));
            wready  = (cnt_w  >= eff(cur_w, lat_w));
            rvalid = 0; rdata = 0;
            if (rd_out) begin
                if (rd_wait >= eff(cur_r, lat_r)) begin
                    rvalid = 1;
                    rdata  = mem_word(rd_addr);
                end else rd_wait++;
            end
            bvalid = 0;
            if (aw_got && w_got) begin
                if (b_wait >= eff(cur_b, lat_b)) bvalid = 1;
                else b_wait++;
            end
            if (spurious) begin
                rvalid = 1;
                bvalid = 1;
            end
            snap();
        end
    end

    task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic f,
                           input bit inject);
        logic [31:0] ra;
        int base_av;
        int t;
        for (int i = 0; i < int'(n); i++) begin
            ra = s + 32'(4 * i);
            exp_ra.push_back(ra);
            exp_wa.push_back(f ? d : d + 32'(4 * i));
            exp_wd.push_back(mem_word(ra));
        end
        done_cnt = 0;
        base_av = av_cnt;
        start = 1; src_addr = s; dst_addr = d;
        len_words = n; dst_fixed = f;
        @(negedge clk); #1;
        start = 0; src_addr = ~s; dst_addr = ~d;
        len_words = ~n; dst_fixed = ~f;
        if (n == 16'd0) begin
            check("zero_done", 64'(done), 64'd1);
            check("zero_busy", 64'(busy), 64'd0);
        end else begin
            check("first_arvalid", 64'(arvalid), 64'd1);
            check("first_busy", 64'(busy), 64'd1);
            check("first_araddr", 64'(araddr), 64'(s));
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
            start = 0;
            if (inject && t == 3 && busy) begin
                start = 1; src_addr = 32'hDEAD0000;
                dst_addr = 32'hBEEF0000; len_words = 16'd7;
            end
        end
        start = 0;
        check("job_done", 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("reads_left", 64'(exp_ra.size()), 64'd0);
        check("writes_left", 64'(exp_wa.size() + exp_wd.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        if (n == 16'd0) check("zero_no_axi", 64'(av_cnt - base_av), 64'd0);
    endtask

    initial begin
        logic [31:0] rs, rd;
        int t;
        resetn = 0; start = 0; src_addr = 0; dst_addr = 0;
        len_words = 0; dst_fixed = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs",
              64'({arvalid, awvalid, wvalid, rready, bready, busy, done}),
              64'd0);
        check("reset_addrs", 64'({araddr, awaddr}), 64'd0);
        check("reset_wdata", 64'(wdata), 64'd0);

        resetn = 1;
        run_job(32'h4000_0000, 32'h5000_0000, 16'd4, 1'b0, 0);
        run_job(32'h4000_1000, 32'h5000_1000, 16'd0, 1'b0, 0);
        run_job(32'h1000_0100, 32'h2000_0000, 16'd3, 1'b1, 0);

        lat_aw = 3; aw_wait = 0; w_cycles = 0;
        run_job(32'h0000_0040, 32'h0000_0080, 16'd1, 1'b0, 0);
        check("aw_wait_cycles", 64'(aw_wait), 64'd3);
        check("w_valid_cycles", 64'(w_cycles), 64'd1);
        lat_aw = 0;

        run_job(32'hFFFF_FFFC, 32'h3000_0000, 16'd2, 1'b0, 0);

        spurious = 1;
        repeat (2) @(negedge clk);
        #1;
        check("spurious_ready", 64'({rready, bready}), 64'd0);
        @(negedge clk); #1;
        check("spurious_idle", 64'({busy, done, arvalid, awvalid}), 64'd0);
        spurious = 0;
        @(negedge clk); #1;

        lat_aw = 2;
        start = 1; src_addr = 32'h0600_0000; dst_addr = 32'h0700_0000;
        len_words = 16'd5; dst_fixed = 0;
        for (int i = 0; i < 5; i++) begin
            exp_ra.push_back(32'h0600_0000 + 32'(4 * i));
            exp_wa.push_back(32'h0700_0000 + 32'(4 * i));
            exp_wd.push_back(mem_word(32'h0600_0000 + 32'(4 * i)));
        end
        done_cnt = 0;
        @(negedge clk); #1;
        start = 0;
        t = 0;
        while (!(awvalid && exp_ra.size() == 3) && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("reach_wr2", 64'(t < 500), 64'd1);
        resetn = 0;
        #1;
        check("rst_outs",
              64'({arvalid, awvalid, wvalid, rready, bready, busy, done}),
              64'd0);
        exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_regs", 64'({araddr, awaddr}), 64'd0);
        lat_aw = 0;
        resetn = 1;
        run_job(32'h0800_0000, 32'h0900_0000, 16'd1, 1'b0, 0);

        rand_lat = 1;
        for (int j = 0; j < 10; j++) begin
            rs = $urandom;
            rd = $urandom;
            run_job(rs & 32'hFFFF_FFFC, rd & 32'hFFFF_FFFC,
                    16'($urandom_range(1, 10)), 1'($urandom_range(0, 1)),
                    1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_dma_master.md
AXI4_DMA_MASTER -- requirements
Module: axi4_dma_master

Interface
REQ-001 Parameter PROT, default 3'b000: value driven constantly on mem_axi_arprot and mem_axi_awprot.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-005 src_addr  in  32  first read byte address, word-aligned; captured on accepted start.
REQ-006 dst_addr  in  32  first write byte address, word-aligned; captured on accepted start.
REQ-007 len_words  in  16  number of 32-bit words to copy; captured on accepted start.
REQ-008 dst_fixed  in  1  1 = destination address held constant (streaming port); captured on accepted start.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse at job completion.
REQ-011 mem_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  out/in/out/out  read address channel.
REQ-012 mem_axi_rvalid/rready/rdata[31:0]  in/out/in  read data channel.
REQ-013 mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  out/in/out/out  write address channel.
REQ-014 mem_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  write data channel.
REQ-015 mem_axi_bvalid/bready  in/out  write response channel; no response code.

Function
REQ-016 The state machine SHALL have states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, FINISH.
REQ-017 IDLE + start + len_words!=0 -> RD_ADDR; IDLE + start + len_words==0 -> FINISH; no AXI traffic for zero length.
REQ-018 RD_ADDR: arvalid=1, araddr=current source; on arvalid&&arready -> RD_DATA.
REQ-019 RD_DATA: rready=1; on rvalid -> latch rdata into the write buffer, -> WR_REQ.
REQ-020 WR_REQ: awvalid and wvalid both asserted on entry; each deasserted independently after its own handshake; -> WR_RESP once both handshakes are done (same or different cycles).
REQ-021 WR_RESP: bready=1; on bvalid -> decrement remaining count; remaining==0 -> FINISH, else -> RD_ADDR.
REQ-022 FINISH: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-023 Latency: start accepted at edge N -> arvalid high from edge N+1; done high the cycle after the final bvalid handshake.
REQ-024 A valid SHALL never drop, and its address/data SHALL never change, before its ready handshake.
REQ-025 Exactly one transaction outstanding: read never overlaps a write; no AXI bursts.
REQ-026 wstrb SHALL be 4'b1111 for every write; wdata SHALL equal the rdata of the paired read.
REQ-027 Source address SHALL advance by 4 per completed read; destination by 4 per completed write unless dst_fixed; both wrap modulo 2^32.
REQ-028 start while not IDLE SHALL be ignored; captured job parameters SHALL not change mid-job.
REQ-029 The remaining counter SHALL be 16 bits; len_words=16'hFFFF copies 65535 words.
REQ-030 rvalid or bvalid arriving outside RD_DATA/WR_RESP SHALL be ignored (ready low).

Reset
REQ-031 resetn low SHALL immediately force IDLE and drive arvalid, awvalid, wvalid, rready, bready, busy and done to 0.
REQ-032 Address registers, counter and write buffer SHALL reset to 0; reset mid-job abandons the job with no done pulse.
REQ-033 The first start SHALL be accepted on the first rising edge after resetn deasserts.

Structure
REQ-034 The state encoding and the AXI word-size constant (4 bytes) SHALL live in a shared package axi4_pkg.
REQ-035 One sub-module SHALL be used: axi4_wr_chan, tracking the independent AW/W handshake completion flags.

Verification
REQ-036 Copy 4 words 0x4000_0000 -> 0x5000_0000 on a zero-wait responder -> 4 reads at +0,+4,+8,+C, matching writes with wstrb=F, one done pulse.
REQ-037 len_words=0 -> done on cycle after start; arvalid/awvalid never asserted.
REQ-038 dst_fixed=1, dst=0x2000_0000, 3 words -> all awaddr=0x2000_0000, data in source order.
REQ-039 Responder delays awready 3 cycles, wready 0 cycles -> wvalid drops after 1 cycle, awvalid/awaddr held stable 3 cycles, WR_RESP entered after both.
REQ-040 src=0xFFFF_FFFC, 2 words -> second araddr=0x0000_0000.
REQ-041 resetn low during WR_REQ of word 2 of 5 -> all valids low same cycle, no done; fresh 1-word job afterwards completes normally.
